// File: rtl/matmul_feeder.sv
// Operand loader for an NxN systolic matrix-multiply array.
// Buffers A and B from a single element stream, replays them to the array
// as N column/row beats, then counts result rows until the product is done.
module matmul_feeder #(
   parameter int DATAWIDTH = 8,
   parameter int N_SIZE    = 3,
   parameter int TIMEOUT   = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [DATAWIDTH-1:0] s_data,
   output logic                 arr_valid_in,
   output logic [DATAWIDTH-1:0] arr_a_out [N_SIZE],
   output logic [DATAWIDTH-1:0] arr_b_out [N_SIZE],
   input  logic                 arr_valid_out,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);

   localparam int BEATS  = 2 * N_SIZE * N_SIZE;
   localparam int IDX_W  = $clog2(BEATS);
   localparam int STEP_W = $clog2(N_SIZE);
   localparam int ROW_W  = $clog2(N_SIZE + 1);
   localparam int WAIT_W = $clog2(TIMEOUT + 1);

   localparam logic [IDX_W-1:0]  LAST_BEAT = IDX_W'(BEATS - 1);
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N_SIZE - 1);
   localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(N_SIZE - 1);
   localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_LOAD,
      ST_STREAM,
      ST_WAIT
   } state_t;

   state_t state, state_nx;

   // A occupies entries 0..N*N-1, B entries N*N..2*N*N-1, both row-major,
   // so the load counter doubles as the write address.
   logic [DATAWIDTH-1:0] elem_buf [BEATS];

   logic [IDX_W-1:0]     load_cnt;
   logic [STEP_W-1:0]    step;
   logic [ROW_W-1:0]     row_cnt;
   logic [WAIT_W-1:0]    wait_cnt;

   logic                 accept;
   logic                 row_hit;
   logic                 done_nx;
   logic                 err_nx;
   logic [STEP_W-1:0]    present_t;
   logic [DATAWIDTH-1:0] col_a [N_SIZE];
   logic [DATAWIDTH-1:0] row_b [N_SIZE];

   assign s_ready = (state == ST_LOAD) && !clear;
   assign accept  = s_valid && s_ready;
   assign row_hit = (state != ST_LOAD) && arr_valid_out && (row_cnt == LAST_ROW);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_LOAD;
      else        state <= state_nx;
   end

   // Next-state and completion/timeout pulse decode; clear overrides everything.
   always_comb begin
      state_nx = state;
      done_nx  = 1'b0;
      err_nx   = 1'b0;
      if (clear) begin
         state_nx = ST_LOAD;
      end else begin
         case (state)
            ST_LOAD: begin
               if (accept && (load_cnt == LAST_BEAT)) state_nx = ST_STREAM;
            end
            ST_STREAM: begin
               if (row_hit) begin
                  state_nx = ST_LOAD;
                  done_nx  = 1'b1;
               end else if (step == LAST_STEP) begin
                  state_nx = ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (row_hit) begin
                  state_nx = ST_LOAD;
                  done_nx  = 1'b1;
               end else if (wait_cnt == LAST_WAIT) begin
                  state_nx = ST_LOAD;
                  err_nx   = 1'b1;
               end
            end
            default: state_nx = ST_LOAD;
         endcase
      end
   end

   // Select the column of A and row of B for the step about to be presented.
   always_comb begin
      present_t = (state == ST_STREAM) ? step + 1'b1 : '0;
      col_a     = '{default: '0};
      row_b     = '{default: '0};
      for (int unsigned i = 0; i < N_SIZE; i++) begin
         col_a[i] = elem_buf[IDX_W'(i * N_SIZE) + IDX_W'(present_t)];
         row_b[i] = elem_buf[IDX_W'(N_SIZE * N_SIZE)
                             + IDX_W'(present_t) * IDX_W'(N_SIZE) + IDX_W'(i)];
      end
   end

   // Operand capture; contents are only meaningful once a full load completes.
   always_ff @(posedge clk) begin
      if (accept) elem_buf[load_cnt] <= s_data;
   end

   // Counters and registered array-side outputs, all derived from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         load_cnt     <= '0;
         step         <= '0;
         row_cnt      <= '0;
         wait_cnt     <= '0;
         arr_valid_in <= 1'b0;
         arr_a_out    <= '{default: '0};
         arr_b_out    <= '{default: '0};
         busy         <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
      end else begin
         done <= done_nx;
         err  <= err_nx;
         busy <= (state_nx != ST_LOAD);
         if (clear) begin
            load_cnt     <= '0;
            step         <= '0;
            row_cnt      <= '0;
            wait_cnt     <= '0;
            arr_valid_in <= 1'b0;
            arr_a_out    <= '{default: '0};
            arr_b_out    <= '{default: '0};
         end else begin
            if (accept) load_cnt <= (load_cnt == LAST_BEAT) ? '0 : load_cnt + 1'b1;
            step     <= (state == ST_STREAM && state_nx == ST_STREAM) ? step + 1'b1 : '0;
            wait_cnt <= (state == ST_WAIT && state_nx == ST_WAIT) ? wait_cnt + 1'b1 : '0;
            // Rows are only counted while an operation is in flight.
            if (state == ST_LOAD || state_nx == ST_LOAD) row_cnt <= '0;
            else                                         row_cnt <= row_cnt + ROW_W'(arr_valid_out);
            if (state_nx == ST_STREAM) begin
               arr_valid_in <= 1'b1;
               arr_a_out    <= col_a;
               arr_b_out    <= row_b;
            end else begin
               arr_valid_in <= 1'b0;
               arr_a_out    <= '{default: '0};
               arr_b_out    <= '{default: '0};
            end
         end
      end
   end

endmodule

// File: tb/tb_matmul_feeder.sv
// Directed self-checking bench for matmul_feeder with N=3, 8-bit elements.
module tb_matmul_feeder;

   logic       clk;
   logic       rst_n;
   logic       clear;
   logic       s_valid;
   logic       s_ready;
   logic [7:0] s_data;
   logic       arr_valid_in;
   logic [7:0] arr_a_out [3];
   logic [7:0] arr_b_out [3];
   logic       arr_valid_out;
   logic       busy;
   logic       done;
   logic       err;

   int pass_cnt  = 0;
   int total_cnt = 0;

   logic [7:0] vals  [18];
   logic [7:0] exp_a [3][3];   // [t][i] = A[i][t]
   logic [7:0] exp_b [3][3];   // [t][j] = B[t][j]

   matmul_feeder #(
      .DATAWIDTH(8),
      .N_SIZE(3),
      .TIMEOUT(64)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .clear(clear),
      .s_valid(s_valid),
      .s_ready(s_ready),
      .s_data(s_data),
      .arr_valid_in(arr_valid_in),
      .arr_a_out(arr_a_out),
      .arr_b_out(arr_b_out),
      .arr_valid_out(arr_valid_out),
      .busy(busy),
      .done(done),
      .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got running exp finished");
      $fatal(1, "watchdog");
   end

   task automatic set_data1();
      vals  = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9,
                8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
      exp_a = '{'{8'd1, 8'd4, 8'd7}, '{8'd2, 8'd5, 8'd8}, '{8'd3, 8'd6, 8'd9}};
      exp_b = '{'{8'd1, 8'd0, 8'd0}, '{8'd0, 8'd1, 8'd0}, '{8'd0, 8'd0, 8'd1}};
   endtask

   task automatic set_data2();
      vals  = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17, 8'd18,
                8'd20, 8'd21, 8'd22, 8'd23, 8'd24, 8'd25, 8'd26, 8'd27, 8'd28};
      exp_a = '{'{8'd10, 8'd13, 8'd16}, '{8'd11, 8'd14, 8'd17}, '{8'd12, 8'd15, 8'd18}};
      exp_b = '{'{8'd20, 8'd21, 8'd22}, '{8'd23, 8'd24, 8'd25}, '{8'd26, 8'd27, 8'd28}};
   endtask

   // Push all 18 elements; with gap set, s_valid drops every other cycle.
   task automatic load_mat(input bit gap);
      bit ok = 1'b1;
      for (int k = 0; k < 18; k++) begin
         if (gap) begin
            s_valid = 1'b0;
            s_data  = 8'h5A;
            @(posedge clk); #1;
         end
         if (s_ready !== 1'b1 || arr_valid_in !== 1'b0) ok = 1'b0;
         s_valid = 1'b1;
         s_data  = vals[k];
         @(posedge clk); #1;
      end
      s_valid = 1'b0;
      total_cnt++;
      if (!ok) $display("FAIL load_ready: got not-ready/early-stream during load, exp ready and idle for 18 beats");
      else     pass_cnt++;
   endtask

   // Called just after the edge entering STREAM; returns in the first WAIT cycle.
   task automatic expect_stream(input string nm);
      for (int t = 0; t < 3; t++) begin
         total_cnt++;
         if (arr_valid_in !== 1'b1 || busy !== 1'b1 || s_ready !== 1'b0)
            $display("FAIL %s ctl t%0d: got vin=%b busy=%b rdy=%b exp 1 1 0", nm, t, arr_valid_in, busy, s_ready);
         else pass_cnt++;
         for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if (arr_a_out[i] !== exp_a[t][i] || arr_b_out[i] !== exp_b[t][i])
               $display("FAIL %s data t%0d[%0d]: got a=%0d b=%0d exp a=%0d b=%0d",
                        nm, t, i, arr_a_out[i], arr_b_out[i], exp_a[t][i], exp_b[t][i]);
            else pass_cnt++;
         end
         @(posedge clk); #1;
      end
      total_cnt++;
      if (arr_valid_in !== 1'b0 || arr_a_out[2] !== 8'd0 || arr_b_out[2] !== 8'd0 || busy !== 1'b1)
         $display("FAIL %s pad: got vin=%b a2=%0d b2=%0d busy=%b exp 0 0 0 1",
                  nm, arr_valid_in, arr_a_out[2], arr_b_out[2], busy);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; clear = 1'b0; s_valid = 1'b0; s_data = '0; arr_valid_out = 1'b0;
      #3;
      total_cnt++;
      if (arr_valid_in !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || s_ready !== 1'b1)
         $display("FAIL reset ctl: got vin=%b busy=%b done=%b err=%b rdy=%b exp 0 0 0 0 1",
                  arr_valid_in, busy, done, err, s_ready);
      else pass_cnt++;
      for (int i = 0; i < 3; i++) begin
         total_cnt++;
         if (arr_a_out[i] !== 8'd0 || arr_b_out[i] !== 8'd0)
            $display("FAIL reset data[%0d]: got a=%0d b=%0d exp 0 0", i, arr_a_out[i], arr_b_out[i]);
         else pass_cnt++;
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   // Idle, then three result rows; done one cycle after the third.
   task automatic test_done(input int idle);
      repeat (idle) begin @(posedge clk); #1; end
      arr_valid_out = 1'b1;
      for (int r = 0; r < 3; r++) begin
         @(posedge clk); #1;
         total_cnt++;
         if (r < 2) begin
            if (done !== 1'b0 || busy !== 1'b1)
               $display("FAIL done_early r%0d: got done=%b busy=%b exp 0 1", r, done, busy);
            else pass_cnt++;
         end else begin
            if (done !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b1 || err !== 1'b0)
               $display("FAIL done_pulse: got done=%b busy=%b rdy=%b err=%b exp 1 0 1 0", done, busy, s_ready, err);
            else pass_cnt++;
         end
      end
      // Still high for one more cycle in LOAD: must be ignored.
      @(posedge clk); #1;
      arr_valid_out = 1'b0;
      total_cnt++;
      if (done !== 1'b0 || busy !== 1'b0 || arr_valid_in !== 1'b0)
         $display("FAIL done_single: got done=%b busy=%b vin=%b exp 0 0 0", done, busy, arr_valid_in);
      else pass_cnt++;
   endtask

   task automatic test_load_stream();
      set_data1();
      load_mat(1'b0);
      expect_stream("stream_b2b");
   endtask

   task automatic test_toggle_valid();
      bit ok = 1'b1;
      set_data1();
      load_mat(1'b1);
      expect_stream("stream_gap");
      s_valid = 1'b1;
      s_data  = 8'hEE;
      repeat (3) begin
         if (s_ready !== 1'b0) ok = 1'b0;
         @(posedge clk); #1;
      end
      s_valid = 1'b0;
      total_cnt++;
      if (!ok) $display("FAIL wait_ready: got s_ready=1 during WAIT exp 0");
      else     pass_cnt++;
   endtask

   task automatic test_timeout();
      bit quiet = 1'b1;
      set_data2();
      load_mat(1'b0);
      expect_stream("stream_to");
      repeat (63) begin
         @(posedge clk); #1;
         if (err !== 1'b0 || done !== 1'b0 || busy !== 1'b1) quiet = 1'b0;
      end
      total_cnt++;
      if (!quiet) $display("FAIL timeout_early: got early err/done/idle exp busy for 64 WAIT cycles");
      else        pass_cnt++;
      @(posedge clk); #1;
      total_cnt++;
      if (err !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b1)
         $display("FAIL timeout_pulse: got err=%b done=%b busy=%b rdy=%b exp 1 0 0 1", err, done, busy, s_ready);
      else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++;
      if (err !== 1'b0) $display("FAIL timeout_single: got err=%b exp 0", err);
      else              pass_cnt++;
      load_mat(1'b0);
      expect_stream("stream_after_to");
      test_done(1);
   endtask

   task automatic test_clear();
      set_data2();
      for (int k = 0; k < 10; k++) begin
         s_valid = 1'b1;
         s_data  = vals[k];
         @(posedge clk); #1;
      end
      s_data = vals[10];
      clear  = 1'b1;
      #1;
      total_cnt++;
      if (s_ready !== 1'b0) $display("FAIL clear_ready: got %b exp 0", s_ready);
      else                  pass_cnt++;
      @(posedge clk); #1;
      clear   = 1'b0;
      s_valid = 1'b0;
      total_cnt++;
      if (busy !== 1'b0 || arr_valid_in !== 1'b0 || done !== 1'b0 || err !== 1'b0)
         $display("FAIL clear_state: got busy=%b vin=%b done=%b err=%b exp 0 0 0 0", busy, arr_valid_in, done, err);
      else pass_cnt++;
      @(posedge clk); #1;
      set_data1();
      load_mat(1'b0);
      expect_stream("stream_after_clr");
      test_done(2);
   endtask

   task automatic test_async_reset();
      set_data1();
      load_mat(1'b0);
      @(posedge clk); #1;
      total_cnt++;
      if (arr_valid_in !== 1'b1 || arr_a_out[0] !== 8'd2)
         $display("FAIL pre_reset step1: got vin=%b a0=%0d exp 1 2", arr_valid_in, arr_a_out[0]);
      else pass_cnt++;
      #2 rst_n = 1'b0;
      #1;
      total_cnt++;
      if (arr_valid_in !== 1'b0 || arr_a_out[0] !== 8'd0 || busy !== 1'b0)
         $display("FAIL async_reset: got vin=%b a0=%0d busy=%b exp 0 0 0", arr_valid_in, arr_a_out[0], busy);
      else pass_cnt++;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      total_cnt++;
      if (s_ready !== 1'b1 || busy !== 1'b0 || arr_valid_in !== 1'b0)
         $display("FAIL reset_release: got rdy=%b busy=%b vin=%b exp 1 0 0", s_ready, busy, arr_valid_in);
      else pass_cnt++;
      set_data2();
      load_mat(1'b0);
      expect_stream("stream_after_rst");
      test_done(0);
   endtask

   // Next load's first beat goes in during the done cycle.
   task automatic test_back_to_back();
      set_data2();
      load_mat(1'b0);
      expect_stream("stream_pre_b2b");
      arr_valid_out = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      arr_valid_out = 1'b0;
      total_cnt++;
      if (done !== 1'b1 || s_ready !== 1'b1)
         $display("FAIL b2b_done: got done=%b rdy=%b exp 1 1", done, s_ready);
      else pass_cnt++;
      set_data1();
      load_mat(1'b0);
      expect_stream("stream_b2b_next");
      test_done(0);
   endtask

   initial begin
      test_reset();
      test_load_stream();
      test_done(4);
      test_toggle_valid();
      test_done(1);
      test_timeout();
      test_clear();
      test_async_reset();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
